frame_buffer_scanout: RTL and testbench
=======================================

Name: frame_buffer_scanout

Overview:
- Read-side counterpart of the board drawer's frame-buffer write port.
- Generates 640x480 VGA timing and reads the 120x120, 24-bit frame buffer through its synchronous read port.
- Each stored pixel is shown as a 4x4 block, centred horizontally, with a border colour outside the image window.
- Also drives the raster position (x, y, active_pixels) consumed by the board drawer.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- FB_W, 120, frame buffer width in pixels
- FB_H, 120, frame buffer height in pixels
- SCALE_SH, 2, log2 of the upscale factor (4x)
- X_OFFSET, 80, first screen column of the image window
- CLK_DIV, 2, clk cycles per pixel tick; must be >= 2
- BORDER_COLOR, 24'h000000, colour outside the image window

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rd_mem_address  out  15  frame buffer read address
- rd_en  out  1  read strobe
- rd_mem_data  in  24  read data {R,G,B}, valid exactly 1 clk after address/rd_en
- vga_r  out  8  red
- vga_g  out  8  green
- vga_b  out  8  blue
- vga_hs  out  1  hsync, active-low
- vga_vs  out  1  vsync, active-low
- vga_blank_n  out  1  high during visible pixels
- pixel_tick  out  1  one-clk pulse per pixel
- x  out  10  current horizontal counter
- y  out  10  current vertical counter
- active_pixels  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- frame_start  out  1  one-clk pulse on the tick where counters become (0,0)

Behaviour:
- Reset (rst=1 at posedge): divider=0, x=0, y=0, rd_mem_address=0, rd_en=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, pixel_tick=0, frame_start=0, active_pixels=0.
- Reset has priority over all activity; a mid-line reset restarts at (0,0) on the next clk.
- Divider:
  - counts 0..CLK_DIV-1;
  - pixel_tick=1 on the clk where divider==CLK_DIV-1;
  - all stages below advance only on that clk.
- Counters:
  - H_TOTAL = 800, V_TOTAL = 525.
  - x increments per tick; at H_TOTAL-1 it wraps to 0 and y increments.
  - y wraps to 0 after V_TOTAL-1.
  - frame_start pulses on the tick where x and y both wrap to 0.
- Image window:
  - X_OFFSET <= x < X_OFFSET + (FB_W << SCALE_SH), and y < (FB_H << SCALE_SH).
  - Default window: columns 80..559, lines 0..479.
- Stage 1 (same tick edge as counter update, computed from the new counter values):
  - In window: rd_en=1, rd_mem_address = (y>>SCALE_SH)*FB_W + ((x-X_OFFSET)>>SCALE_SH).
  - Computed at 15 bits; maximum value 14399; never exceeds FB_W*FB_H-1.
  - Out of window: rd_en=0, address holds its previous value.
  - win_d, hs_d, vs_d and blank_d are registered alongside.
- Stage 2 (next tick): rgb = win_d ? rd_mem_data : BORDER_COLOR, forced to 0 when blank_d; vga_hs, vga_vs and vga_blank_n take the delayed flags.
- Output latency: exactly one pixel tick from counter value (x,y) to its colour and sync. x, y and active_pixels are undelayed, so the drawer sees the counter domain.
- Sync timing:
  - vga_hs low for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vga_vs low for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
- Memory contract: data is sampled CLK_DIV clk after address issue (1 clk read latency plus slack). rd_en is a level per tick; the block has no backpressure.

Test Plan:
- Hold rst=1 for 5 clk with random rd_mem_data -> every output at its reset value; first pixel_tick 2 clk after rst deasserts.
- 1-clk-latency RAM model, mem[0]=FFFFFF, mem[1]=98F5F9 -> rd_mem_address=0 for x=80..83 on y=0..3 and 1 for x=84..87; rgb FFFFFF at screen columns 80..83 one tick later, then 98F5F9.
- Scan a full frame -> max address 14399 at (x=559, y=479); rd_en=0 and rgb=000000 for x<80 or 560<=x<640; blank_n=0 and rgb=0 for x>=640 or y>=480.
- Sync check -> hs low for 96 ticks starting at x=656 (seen one tick later at outputs); vs low for lines 490..491; frame_start period exactly 420000 ticks (840000 clk).
- Assert rst for 1 clk at x=300, y=200 -> next clk x=0, y=0, hs=1, vs=1, blank_n=0; timing restarts cleanly.
- CLK_DIV=4 instance -> pixel_tick every 4 clk; colours still aligned with a 1-tick lag.

Source files
------------

// File: rtl/frame_buffer_scanout.sv
// -----------------------------------------------------------------------------
// frame_buffer_scanout
//
// Read side of the board frame buffer. Generates 640x480 VGA timing, fetches
// the 120x120 24-bit frame buffer through its synchronous read port and shows
// each stored pixel as a (1 << SCALE_SH)-square block. The image window starts
// at column X_OFFSET. Visible pixels outside the window get BORDER_COLOR. The
// undelayed raster position is also exported so the board drawer can track
// the beam.
//
// Pipeline (every stage advances only on a pixel tick):
//   counters : x, y, active_pixels, frame_start (registered from next values)
//   stage 1  : read address / rd_en plus delayed window, sync and blank flags
//   stage 2  : colour select and registered sync / blank outputs
// The colour and sync outputs therefore lag the counters by one pixel tick.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   rd_mem_address     frame buffer read address (held while out of window)
//   rd_en              read strobe, a level that lasts one pixel tick
//   rd_mem_data        read data {R,G,B}, valid 1 clk after address/rd_en
//   vga_r/g/b          pixel colour
//   vga_hs, vga_vs     active-low syncs
//   vga_blank_n        high during visible pixels
//   pixel_tick         one-clk pulse per pixel, aligned with new counter values
//   x, y               raster counters
//   active_pixels      high when x < H_ACTIVE and y < V_ACTIVE
//   frame_start        one-clk pulse on the tick where the counters become (0,0)
// -----------------------------------------------------------------------------
module frame_buffer_scanout #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          FB_W         = 120,
  parameter int          FB_H         = 120,
  parameter int          SCALE_SH     = 2,
  parameter int          X_OFFSET     = 80,
  parameter int          CLK_DIV      = 2,
  parameter logic [23:0] BORDER_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [14:0] rd_mem_address,
  output logic        rd_en,
  input  logic [23:0] rd_mem_data,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        pixel_tick,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        active_pixels,
  output logic        frame_start
);

  // ---------------------------------------------------------------------------
  // Derived timing constants
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Image window in screen coordinates
  localparam logic [9:0] WIN_X_LO = 10'(X_OFFSET);
  localparam logic [9:0] WIN_X_HI = 10'(X_OFFSET + (FB_W << SCALE_SH));
  localparam logic [9:0] WIN_Y_HI = 10'(FB_H << SCALE_SH);

  localparam logic [14:0] FB_W_15 = 15'(FB_W);

  localparam int              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  logic             r_frame_start;

  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_active;

  logic [14:0]      r_addr;
  logic             r_rd_en;
  logic             r_win_d;
  logic             r_hs_d;
  logic             r_vs_d;
  logic             r_blank_d;     // high = blanking interval

  logic [23:0]      r_rgb;
  logic             r_hs;
  logic             r_vs;
  logic             r_blank_n;

  // ---------------------------------------------------------------------------
  // Combinational next-state
  // ---------------------------------------------------------------------------
  logic        w_tick_en;
  logic        w_x_wrap;
  logic        w_y_wrap;
  logic [9:0]  w_x_nxt;
  logic [9:0]  w_y_nxt;
  logic        w_visible;
  logic        w_in_win;
  logic        w_hs_nxt;
  logic        w_vs_nxt;
  logic [9:0]  w_col_off;
  logic [9:0]  w_row;
  logic [14:0] w_addr;

  assign w_tick_en = (r_div == DIV_LAST);
  assign w_x_wrap  = (r_x == H_LAST);
  assign w_y_wrap  = (r_y == V_LAST);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_x_nxt = r_x + 10'd1;
    w_y_nxt = r_y;
    if (w_x_wrap) begin
      w_x_nxt = 10'd0;
      w_y_nxt = w_y_wrap ? 10'd0 : r_y + 10'd1;
    end
  end

  // Stage 1 decodes the position the counters are about to take, so the read
  // issued on a tick belongs to the same (x, y) the counters show after it.
  assign w_visible = (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
  assign w_in_win  = (w_x_nxt >= WIN_X_LO) && (w_x_nxt < WIN_X_HI) &&
                     (w_y_nxt < WIN_Y_HI);
  assign w_hs_nxt  = !((w_x_nxt >= HS_START) && (w_x_nxt < HS_END));
  assign w_vs_nxt  = !((w_y_nxt >= VS_START) && (w_y_nxt < VS_END));

  // Frame buffer is row-major, FB_W words per row. Only meaningful inside the
  // window, where the result stays below FB_W*FB_H.
  assign w_col_off = w_x_nxt - WIN_X_LO;
  assign w_row     = w_y_nxt >> SCALE_SH;
  assign w_addr    = (15'(w_row) * FB_W_15) + 15'(w_col_off >> SCALE_SH);

  // ---------------------------------------------------------------------------
  // Clock divider and one-clk strobes
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div         <= '0;
      r_tick        <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_tick_en ? '0 : r_div + DIV_ONE;
      // Strobes are registered from the tick enable, so they are high in the
      // clk that follows the counter update and last exactly one clk.
      r_tick        <= w_tick_en;
      r_frame_start <= w_tick_en && w_x_wrap && w_y_wrap;
    end
  end

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= 10'd0;
      r_y      <= 10'd0;
      r_active <= 1'b0;
    end else if (w_tick_en) begin
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_active <= w_visible;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: read request and delayed control flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= 15'd0;
      r_rd_en   <= 1'b0;
      r_win_d   <= 1'b0;
      r_hs_d    <= 1'b1;
      r_vs_d    <= 1'b1;
      r_blank_d <= 1'b1;
    end else if (w_tick_en) begin
      r_rd_en   <= w_in_win;
      // Outside the window the address is left alone; rd_en low marks it idle.
      if (w_in_win) begin
        r_addr <= w_addr;
      end
      r_win_d   <= w_in_win;
      r_hs_d    <= w_hs_nxt;
      r_vs_d    <= w_vs_nxt;
      r_blank_d <= !w_visible;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour select. rd_mem_data has been stable since 1 clk after the
  // read was issued, and is sampled CLK_DIV clk after issue.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb     <= 24'h000000;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
    end else if (w_tick_en) begin
      if (r_blank_d) begin
        r_rgb <= 24'h000000;
      end else if (r_win_d) begin
        r_rgb <= rd_mem_data;
      end else begin
        r_rgb <= BORDER_COLOR;
      end
      r_hs      <= r_hs_d;
      r_vs      <= r_vs_d;
      r_blank_n <= !r_blank_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_mem_address = r_addr;
  assign rd_en          = r_rd_en;
  assign vga_r          = r_rgb[23:16];
  assign vga_g          = r_rgb[15:8];
  assign vga_b          = r_rgb[7:0];
  assign vga_hs         = r_hs;
  assign vga_vs         = r_vs;
  assign vga_blank_n    = r_blank_n;
  assign pixel_tick     = r_tick;
  assign x              = r_x;
  assign y              = r_y;
  assign active_pixels  = r_active;
  assign frame_start    = r_frame_start;

endmodule

// File: tb/tb_frame_buffer_scanout.sv
// -----------------------------------------------------------------------------
// Testbench for frame_buffer_scanout.
//
// u_dut0: default 640x480 timing, CLK_DIV=2. Used for reset values, the first
//         image lines (table of raster positions with expected read address
//         and colour one tick later) and a mid-line reset.
// u_dut1: shrunken timing (56x30 total, 8x6 buffer, CLK_DIV=4, non-black
//         border), scanned over two complete frames against a small model.
// Each instance has a 1-clk-latency RAM model that returns random data while
// its reset is held.
// -----------------------------------------------------------------------------
module tb_frame_buffer_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Frame buffer contents shared by both RAM models
  function automatic logic [23:0] mem_val(input logic [14:0] a);
    if (a == 15'd0) return 24'hFFFFFF;
    if (a == 15'd1) return 24'h98F5F9;
    return {a[7:0] ^ 8'h3C, 1'b1, a[14:8], ~a[7:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Default instance
  // ---------------------------------------------------------------------------
  logic        rst0 = 1'b1;
  logic [14:0] addr0;
  logic        rd_en0;
  logic [23:0] rd_data0 = 24'h0;
  logic [7:0]  r0, g0, b0;
  logic        hs0, vs0, bn0, tick0, act0, fs0;
  logic [9:0]  x0, y0;
  logic [23:0] rgb0;
  assign rgb0 = {r0, g0, b0};

  frame_buffer_scanout u_dut0 (
    .clk(clk), .rst(rst0),
    .rd_mem_address(addr0), .rd_en(rd_en0), .rd_mem_data(rd_data0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0),
    .vga_hs(hs0), .vga_vs(vs0), .vga_blank_n(bn0),
    .pixel_tick(tick0), .x(x0), .y(y0),
    .active_pixels(act0), .frame_start(fs0)
  );

  always @(posedge clk) begin
    if (rst0) rd_data0 <= 24'($urandom);
    else if (rd_en0) rd_data0 <= mem_val(addr0);
  end

  // ---------------------------------------------------------------------------
  // Small instance
  // ---------------------------------------------------------------------------
  logic        rst1 = 1'b1;
  logic [14:0] addr1;
  logic        rd_en1;
  logic [23:0] rd_data1 = 24'h0;
  logic [7:0]  r1, g1, b1;
  logic        hs1, vs1, bn1, tick1, act1, fs1;
  logic [9:0]  x1, y1;
  logic [23:0] rgb1;
  assign rgb1 = {r1, g1, b1};

  frame_buffer_scanout #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .FB_W(8), .FB_H(6), .SCALE_SH(2), .X_OFFSET(4),
    .CLK_DIV(4), .BORDER_COLOR(24'h123456)
  ) u_dut1 (
    .clk(clk), .rst(rst1),
    .rd_mem_address(addr1), .rd_en(rd_en1), .rd_mem_data(rd_data1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .vga_hs(hs1), .vga_vs(vs1), .vga_blank_n(bn1),
    .pixel_tick(tick1), .x(x1), .y(y1),
    .active_pixels(act1), .frame_start(fs1)
  );

  always @(posedge clk) begin
    if (rst1) rd_data1 <= 24'($urandom);
    else if (rd_en1) rd_data1 <= mem_val(addr1);
  end

  // ---------------------------------------------------------------------------
  // Check helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Advance to the next negedge where u_dut0 shows a pixel tick
  task automatic next_tick0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tick0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Advance tick by tick until u_dut0 counters show (tx, ty)
  task automatic wait_pos0(input logic [9:0] tx, input logic [9:0] ty,
                           output bit ok);
    ok = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      if (x0 == tx && y0 == ty) break;
      next_tick0(ok);
      if (!ok) break;
    end
    if (!(x0 == tx && y0 == ty)) ok = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Position table for u_dut0: stage-1 outputs at (x,y), colour/sync one tick
  // later
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        rd_en;
    logic [14:0] addr;
    logic        active;
    logic [23:0] rgb;
    logic        blank_n;
    logic        hs;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  initial begin
    bit ok;

    vecs[0]  = '{10'd1,   10'd0, 1'b0, 15'd0,   1'b1, 24'h000000,   1'b1, 1'b1};
    vecs[1]  = '{10'd79,  10'd0, 1'b0, 15'd0,   1'b1, 24'h000000,   1'b1, 1'b1};
    vecs[2]  = '{10'd80,  10'd0, 1'b1, 15'd0,   1'b1, 24'hFFFFFF,   1'b1, 1'b1};
    vecs[3]  = '{10'd83,  10'd0, 1'b1, 15'd0,   1'b1, 24'hFFFFFF,   1'b1, 1'b1};
    vecs[4]  = '{10'd84,  10'd0, 1'b1, 15'd1,   1'b1, 24'h98F5F9,   1'b1, 1'b1};
    vecs[5]  = '{10'd87,  10'd0, 1'b1, 15'd1,   1'b1, 24'h98F5F9,   1'b1, 1'b1};
    vecs[6]  = '{10'd559, 10'd0, 1'b1, 15'd119, 1'b1, 24'h4B8088,   1'b1, 1'b1};
    vecs[7]  = '{10'd560, 10'd0, 1'b0, 15'd119, 1'b1, 24'h000000,   1'b1, 1'b1};
    vecs[8]  = '{10'd639, 10'd0, 1'b0, 15'd119, 1'b1, 24'h000000,   1'b1, 1'b1};
    vecs[9]  = '{10'd640, 10'd0, 1'b0, 15'd119, 1'b0, 24'h000000,   1'b0, 1'b1};
    vecs[10] = '{10'd655, 10'd0, 1'b0, 15'd119, 1'b0, 24'h000000,   1'b0, 1'b1};
    vecs[11] = '{10'd656, 10'd0, 1'b0, 15'd119, 1'b0, 24'h000000,   1'b0, 1'b0};
    vecs[12] = '{10'd751, 10'd0, 1'b0, 15'd119, 1'b0, 24'h000000,   1'b0, 1'b0};
    vecs[13] = '{10'd752, 10'd0, 1'b0, 15'd119, 1'b0, 24'h000000,   1'b0, 1'b1};
    vecs[14] = '{10'd799, 10'd0, 1'b0, 15'd119, 1'b0, 24'h000000,   1'b0, 1'b1};
    vecs[15] = '{10'd80,  10'd3, 1'b1, 15'd0,   1'b1, 24'hFFFFFF,   1'b1, 1'b1};
    vecs[16] = '{10'd84,  10'd3, 1'b1, 15'd1,   1'b1, 24'h98F5F9,   1'b1, 1'b1};
    vecs[17] = '{10'd80,  10'd4, 1'b1, 15'd120, 1'b1, mem_val(15'd120), 1'b1, 1'b1};
    vecs[18] = '{10'd85,  10'd4, 1'b1, 15'd121, 1'b1, mem_val(15'd121), 1'b1, 1'b1};
    vecs[19] = '{10'd299, 10'd4, 1'b1, 15'd174, 1'b1, mem_val(15'd174), 1'b1, 1'b1};

    // ---- Reset held 5 clk with random read data ----
    repeat (5) @(negedge clk);
    check("rst_addr",    addr0,  15'd0);
    check("rst_rd_en",   rd_en0, 1'b0);
    check("rst_rgb",     rgb0,   24'h0);
    check("rst_hs",      hs0,    1'b1);
    check("rst_vs",      vs0,    1'b1);
    check("rst_blank_n", bn0,    1'b0);
    check("rst_tick",    tick0,  1'b0);
    check("rst_x",       x0,     10'd0);
    check("rst_y",       y0,     10'd0);
    check("rst_active",  act0,   1'b0);
    check("rst_fs",      fs0,    1'b0);
    check("rst1_rgb",    rgb1,   24'h0);
    rst0 = 1'b0;
    @(negedge clk);
    check("tick_1clk_after_rst", tick0, 1'b0);
    @(negedge clk);
    check("tick_2clk_after_rst", tick0, 1'b1);
    check("first_tick_x",        x0,    10'd1);

    // ---- Table of raster positions ----
    for (int i = 0; i < NV; i++) begin
      wait_pos0(vecs[i].x, vecs[i].y, ok);
      if (!ok) begin
        fail_now($sformatf("v%0d_wait", i));
        continue;
      end
      check($sformatf("v%0d_rd_en", i),  rd_en0, vecs[i].rd_en);
      check($sformatf("v%0d_addr", i),   addr0,  vecs[i].addr);
      check($sformatf("v%0d_active", i), act0,   vecs[i].active);
      next_tick0(ok);
      if (!ok) begin
        fail_now($sformatf("v%0d_tick", i));
        continue;
      end
      check($sformatf("v%0d_rgb", i),     rgb0, vecs[i].rgb);
      check($sformatf("v%0d_blank_n", i), bn0,  vecs[i].blank_n);
      check($sformatf("v%0d_hs", i),      hs0,  vecs[i].hs);
      check($sformatf("v%0d_vs", i),      vs0,  1'b1);
    end

    // ---- Mid-line reset at (300,4) ----
    check("pre_rst_x", x0, 10'd300);
    check("pre_rst_y", y0, 10'd4);
    rst0 = 1'b1;
    @(negedge clk);
    check("mrst_x",       x0,     10'd0);
    check("mrst_y",       y0,     10'd0);
    check("mrst_hs",      hs0,    1'b1);
    check("mrst_vs",      vs0,    1'b1);
    check("mrst_blank_n", bn0,    1'b0);
    check("mrst_rd_en",   rd_en0, 1'b0);
    check("mrst_addr",    addr0,  15'd0);
    check("mrst_rgb",     rgb0,   24'h0);
    rst0 = 1'b0;
    @(negedge clk);
    check("mrst_tick_1clk", tick0, 1'b0);
    @(negedge clk);
    check("mrst_tick_2clk", tick0, 1'b1);
    check("mrst_first_x",   x0,    10'd1);
    wait_pos0(10'd80, 10'd0, ok);
    if (!ok) fail_now("mrst_wait80");
    check("mrst_addr80", addr0, 15'd0);
    next_tick0(ok);
    if (!ok) fail_now("mrst_tick81");
    check("mrst_rgb80", rgb0, 24'hFFFFFF);
    wait_pos0(10'd84, 10'd0, ok);
    if (!ok) fail_now("mrst_wait84");
    check("mrst_addr84", addr0, 15'd1);
    next_tick0(ok);
    if (!ok) fail_now("mrst_tick85");
    check("mrst_rgb84", rgb0, 24'h98F5F9);

    // ---- Small instance: two full frames against a model ----
    begin
      int          last_tick = -1;
      int          fs_n = 0;
      int          fs_clk[2];
      int          mx = 0, my = 0;
      int          e_addr;
      bit          have_prev = 1'b0;
      bit          win, vis;
      logic [23:0] e_rgb = 24'h0;
      logic        e_hs = 1'b1, e_vs = 1'b1, e_bn = 1'b0;
      logic [14:0] max_a = 15'd0;
      logic [9:0]  max_x = 10'd0, max_y = 10'd0;

      rst1 = 1'b0;
      for (int c = 0; c < 16000 && fs_n < 2; c++) begin
        @(negedge clk);
        if (tick1) begin
          if (last_tick >= 0) check("s_tick_gap", c - last_tick, 4);
          last_tick = c;
          if (mx == 55) begin
            mx = 0;
            my = (my == 29) ? 0 : my + 1;
          end else begin
            mx++;
          end
          check("s_x", x1, mx);
          check("s_y", y1, my);
          check("s_frame_start", fs1, (mx == 0 && my == 0));
          if (mx == 0 && my == 0) begin
            fs_clk[fs_n] = c;
            fs_n++;
          end
          win    = (mx >= 4) && (mx < 36) && (my < 24);
          vis    = (mx < 40) && (my < 24);
          e_addr = (my >> 2) * 8 + ((mx - 4) >> 2);
          check("s_rd_en", rd_en1, win);
          if (win) check("s_addr", addr1, e_addr);
          check("s_active", act1, vis);
          if (have_prev) begin
            check("s_rgb",     rgb1, e_rgb);
            check("s_hs",      hs1,  e_hs);
            check("s_vs",      vs1,  e_vs);
            check("s_blank_n", bn1,  e_bn);
          end
          e_bn  = vis;
          e_rgb = !vis ? 24'h0 : (win ? mem_val(15'(e_addr)) : 24'h123456);
          e_hs  = !((mx >= 44) && (mx < 52));
          e_vs  = !((my >= 26) && (my < 28));
          have_prev = 1'b1;
          if (rd_en1 && addr1 >= max_a) begin
            max_a = addr1;
            max_x = x1;
            max_y = y1;
          end
        end else begin
          check("s_fs_idle", fs1, 1'b0);
        end
      end
      if (fs_n < 2) begin
        fail_now("s_frame_start");
      end else begin
        check("s_frame_period_clk", fs_clk[1] - fs_clk[0], 6720);
      end
      check("s_max_addr",   max_a, 15'd47);
      check("s_max_addr_x", max_x, 10'd35);
      check("s_max_addr_y", max_y, 10'd23);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
